reg_operand_fetch: RTL and testbench

- Read-side companion to the per-register reserve/writeback cells.
- Accepts decoded issue requests (rs1, rs2, rd) and checks the reserve bits of every register it touches. Stalls while any is reserved, with same-cycle writeback bypass.
- On issue, fetches both operands, pulses the write-reserve for rd, and presents operands to execute through a valid/ready register slice.
- Sits between decode and execute, beside the register file.

---
 rtl/reg_operand_fetch_pkg.sv | 13 +
 rtl/reg_operand_fetch_operand_bypass_mux.sv | 34 +++
 rtl/reg_operand_fetch.sv | 155 +++++++++++++++
 tb/tb_reg_operand_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_operand_fetch_pkg.sv
// Shared sizing constants for the operand fetch stage.
package reg_operand_fetch_pkg;

  // Data word width, architectural register count and register index width.
  localparam int unsigned WORD = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  // Hazard-stall counter width and its saturation value.
  localparam int unsigned      STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/reg_operand_fetch_operand_bypass_mux.sv
// One source operand: picks register cell data or same-cycle writeback data,
// and flags a read hazard when the source is reserved and not being bypassed.
module operand_bypass_mux
  import reg_operand_fetch_pkg::*;
#(
  parameter int unsigned WORD_P = WORD,
  parameter int unsigned NREG_P = NREG,
  parameter int unsigned AW_P   = AW
) (
  input  logic [NREG_P*WORD_P-1:0] rf_data_i,
  input  logic [NREG_P-1:0]        rf_reserved_i,
  input  logic [AW_P-1:0]          idx_i,
  input  logic                     use_i,
  input  logic                     wb_i,
  input  logic [AW_P-1:0]          wb_addr_i,
  input  logic [WORD_P-1:0]        wb_data_i,
  output logic [WORD_P-1:0]        data_o,
  output logic                     hz_o
);

  logic byp;

  // Bypass select, zeroed operand when unused, and per-source hazard.
  always_comb begin
    byp    = wb_i && (wb_addr_i == idx_i);
    data_o = '0;
    if (use_i) begin
      if (byp) data_o = wb_data_i;
      else     data_o = rf_data_i[idx_i*WORD_P +: WORD_P];
    end
    hz_o = use_i && rf_reserved_i[idx_i] && !byp;
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: captures a decoded request, waits out reserved
// registers (with writeback bypass), reserves rd on issue and hands the
// operands to execute through a valid/ready output slice.
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int unsigned WORD_P = WORD,
  parameter int unsigned NREG_P = NREG,
  parameter int unsigned AW_P   = AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AW_P-1:0]          rs1_i,
  input  logic [AW_P-1:0]          rs2_i,
  input  logic                     use_rs1_i,
  input  logic                     use_rs2_i,
  input  logic [AW_P-1:0]          rd_i,
  input  logic                     rd_we_i,
  input  logic [NREG_P*WORD_P-1:0] rf_data_i,
  input  logic [NREG_P-1:0]        rf_reserved_i,
  output logic [NREG_P-1:0]        reserve_o,
  input  logic                     wb_i,
  input  logic [AW_P-1:0]          wb_addr_i,
  input  logic [WORD_P-1:0]        wb_data_i,
  output logic                     op_valid_o,
  input  logic                     op_ready_i,
  output logic [WORD_P-1:0]        op_a_o,
  output logic [WORD_P-1:0]        op_b_o,
  output logic [AW_P-1:0]          op_rd_o,
  output logic                     op_rd_we_o,
  output logic [STALL_W-1:0]       stall_cnt_o
);

  // S1 holding register
  logic            s1_valid;
  logic [AW_P-1:0] s1_rs1;
  logic [AW_P-1:0] s1_rs2;
  logic [AW_P-1:0] s1_rd;
  logic            s1_use1;
  logic            s1_use2;
  logic            s1_rd_we;

  logic [WORD_P-1:0] src_a;
  logic [WORD_P-1:0] src_b;
  logic              hz_a;
  logic              hz_b;
  logic              hz_dst;
  logic              hazard;
  logic              s1_fire;
  logic              req_take;

  operand_bypass_mux #(
    .WORD_P (WORD_P),
    .NREG_P (NREG_P),
    .AW_P   (AW_P)
  ) u_mux_a (
    .rf_data_i     (rf_data_i),
    .rf_reserved_i (rf_reserved_i),
    .idx_i         (s1_rs1),
    .use_i         (s1_use1),
    .wb_i          (wb_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .data_o        (src_a),
    .hz_o          (hz_a)
  );

  operand_bypass_mux #(
    .WORD_P (WORD_P),
    .NREG_P (NREG_P),
    .AW_P   (AW_P)
  ) u_mux_b (
    .rf_data_i     (rf_data_i),
    .rf_reserved_i (rf_reserved_i),
    .idx_i         (s1_rs2),
    .use_i         (s1_use2),
    .wb_i          (wb_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .data_o        (src_b),
    .hz_o          (hz_b)
  );

  // Hazard detection, issue decision and request handshake.
  // WAW also stalls: each cell has only one reserve bit to track a writer.
  always_comb begin
    hz_dst      = s1_rd_we && rf_reserved_i[s1_rd] &&
                  !(wb_i && (wb_addr_i == s1_rd));
    hazard      = hz_a || hz_b || hz_dst;
    s1_fire     = s1_valid && !hazard && (!op_valid_o || op_ready_i);
    req_ready_o = !s1_valid || s1_fire;
    req_take    = req_valid_i && req_ready_o;
  end

  // One-hot reserve pulse for rd in the issue cycle; the cell shows it
  // reserved from the next cycle, which is what stalls a dependent in S1.
  always_comb begin
    reserve_o = '0;
    if (s1_fire && s1_rd_we) reserve_o[s1_rd] = 1'b1;
  end

  // S1 capture: load on accept, empty on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_rd    <= '0;
      s1_use1  <= 1'b0;
      s1_use2  <= 1'b0;
      s1_rd_we <= 1'b0;
    end else if (req_take) begin
      s1_valid <= 1'b1;
      s1_rs1   <= rs1_i;
      s1_rs2   <= rs2_i;
      s1_rd    <= rd_i;
      s1_use1  <= use_rs1_i;
      s1_use2  <= use_rs2_i;
      s1_rd_we <= rd_we_i;
    end else if (s1_fire) begin
      s1_valid <= 1'b0;
    end
  end

  // Output slice: load on issue, drop valid once execute takes it, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_o <= 1'b0;
      op_a_o     <= '0;
      op_b_o     <= '0;
      op_rd_o    <= '0;
      op_rd_we_o <= 1'b0;
    end else if (s1_fire) begin
      op_valid_o <= 1'b1;
      op_a_o     <= src_a;
      op_b_o     <= src_b;
      op_rd_o    <= s1_rd;
      op_rd_we_o <= s1_rd_we;
    end else if (op_ready_i) begin
      op_valid_o <= 1'b0;
    end
  end

  // Saturating count of cycles spent stalled on a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (s1_valid && hazard && (stall_cnt_o != STALL_MAX)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch with a small behavioural model of the
// register cells' reserve bits (reserve wins over same-cycle unreserve).
module tb_reg_operand_fetch;
  import reg_operand_fetch_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AW-1:0]        rs1_i, rs2_i, rd_i;
  logic                 use_rs1_i, use_rs2_i, rd_we_i;
  logic [NREG*WORD-1:0] rf_data_i;
  logic [NREG-1:0]      rf_reserved_i;
  logic [NREG-1:0]      reserve_o;
  logic                 wb_i;
  logic [AW-1:0]        wb_addr_i;
  logic [WORD-1:0]      wb_data_i;
  logic                 op_valid_o;
  logic                 op_ready_i;
  logic [WORD-1:0]      op_a_o, op_b_o;
  logic [AW-1:0]        op_rd_o;
  logic                 op_rd_we_o;
  logic [STALL_W-1:0]   stall_cnt_o;

  logic [WORD-1:0] rf_mem [NREG];
  logic [NREG-1:0] cell_res;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_vec;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_operand_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .use_rs1_i     (use_rs1_i),
    .use_rs2_i     (use_rs2_i),
    .rd_i          (rd_i),
    .rd_we_i       (rd_we_i),
    .rf_data_i     (rf_data_i),
    .rf_reserved_i (rf_reserved_i),
    .reserve_o     (reserve_o),
    .wb_i          (wb_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .op_valid_o    (op_valid_o),
    .op_ready_i    (op_ready_i),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .op_rd_o       (op_rd_o),
    .op_rd_we_o    (op_rd_we_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Flatten the register data array onto the cell data bus.
  always_comb begin
    rf_data_i = '0;
    for (int k = 0; k < NREG; k++) rf_data_i[k*WORD +: WORD] = rf_mem[k];
  end

  assign clr_vec       = wb_i ? (NREG'(1) << wb_addr_i) : '0;
  assign rf_reserved_i = cell_res;

  // Reserve-bit cells: set by reserve pulse or bench preset, cleared by wb.
  always @(posedge clk or posedge rst) begin
    if (rst) cell_res <= '0;
    else     cell_res <= (cell_res & ~clr_vec) | reserve_o | set_mask;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [AW-1:0] a, input logic ua,
                           input logic [AW-1:0] b, input logic ub,
                           input logic [AW-1:0] d, input logic dwe);
    req_valid_i = v;
    rs1_i = a; use_rs1_i = ua;
    rs2_i = b; use_rs2_i = ub;
    rd_i  = d; rd_we_i   = dwe;
  endtask

  task automatic drive_wb(input logic w, input logic [AW-1:0] a, input logic [WORD-1:0] d);
    wb_i = w; wb_addr_i = a; wb_data_i = d;
  endtask

  initial begin
    rst = 1'b1;
    set_mask = '0;
    op_ready_i = 1'b1;
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive_wb(1'b0, '0, '0);
    for (int k = 0; k < NREG; k++) rf_mem[k] = '0;
    rf_mem[2] = 32'h02;
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    rf_mem[6] = 32'h66;

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_op_valid", 64'(op_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
    chk("rst_reserve", 64'(reserve_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);

    // Basic issue: rs1=3 rs2=4 rd=5
    step();
    drive_req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1);
    #1;
    chk("t1_req_ready", 64'(req_ready_o), 64'd1);
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("t1_reserve_pulse", 64'(reserve_o), 64'(32'h1 << 5));
    chk("t1_op_valid_early", 64'(op_valid_o), 64'd0);
    step();
    chk("t1_op_valid", 64'(op_valid_o), 64'd1);
    chk("t1_op_a", 64'(op_a_o), 64'h11);
    chk("t1_op_b", 64'(op_b_o), 64'h22);
    chk("t1_op_rd", 64'(op_rd_o), 64'd5);
    chk("t1_op_rd_we", 64'(op_rd_we_o), 64'd1);
    chk("t1_reserve_gone", 64'(reserve_o), 64'd0);
    // retire r5
    drive_wb(1'b1, 5'd5, 32'h55);
    step();
    drive_wb(1'b0, '0, '0);

    // Back-to-back RAW: I0 rd=5, then I1 rs1=5 rd=6
    drive_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    step();
    drive_req(1'b1, 5'd5, 1'b1, 5'd3, 1'b0, 5'd6, 1'b1);
    #1;
    chk("t2_i0_reserve", 64'(reserve_o), 64'(32'h1 << 5));
    chk("t2_i1_accept", 64'(req_ready_o), 64'd1);
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("t2_stall_ready", 64'(req_ready_o), 64'd0);
    chk("t2_stall_reserve", 64'(reserve_o), 64'd0);
    step();
    chk("t2_stall_cnt1", 64'(stall_cnt_o), 64'd1);
    chk("t2_op_drained", 64'(op_valid_o), 64'd0);
    step();
    chk("t2_stall_cnt2", 64'(stall_cnt_o), 64'd2);
    drive_wb(1'b1, 5'd5, 32'hAB);
    #1;
    chk("t2_fire_reserve", 64'(reserve_o), 64'(32'h1 << 6));
    step();
    drive_wb(1'b0, '0, '0);
    chk("t2_op_valid", 64'(op_valid_o), 64'd1);
    chk("t2_op_a_bypass", 64'(op_a_o), 64'hAB);
    chk("t2_op_b_unused", 64'(op_b_o), 64'd0);
    chk("t2_op_rd", 64'(op_rd_o), 64'd6);
    chk("t2_stall_final", 64'(stall_cnt_o), 64'd2);
    // retire r6
    drive_wb(1'b1, 5'd6, 32'h0);
    step();
    drive_wb(1'b0, '0, '0);

    // WAW: r7 reserved externally, request rd=7 with no sources
    set_mask = NREG'(1) << 7;
    step();
    set_mask = '0;
    drive_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("t3_waw_no_reserve", 64'(reserve_o), 64'd0);
    chk("t3_waw_ready", 64'(req_ready_o), 64'd0);
    step();
    chk("t3_stall3", 64'(stall_cnt_o), 64'd3);
    step();
    chk("t3_stall4", 64'(stall_cnt_o), 64'd4);
    drive_wb(1'b1, 5'd7, 32'h77);
    #1;
    chk("t3_waw_reserve", 64'(reserve_o), 64'(32'h1 << 7));
    step();
    drive_wb(1'b0, '0, '0);
    chk("t3_op_rd", 64'(op_rd_o), 64'd7);
    chk("t3_op_valid", 64'(op_valid_o), 64'd1);
    chk("t3_stall_held", 64'(stall_cnt_o), 64'd4);
    // retire r7, slice drains
    drive_wb(1'b1, 5'd7, 32'h0);
    step();
    drive_wb(1'b0, '0, '0);

    // Backpressure: A (rs1=2,rs2=6,rd=8) then B (rs1=3,rs2=4,rd=9)
    op_ready_i = 1'b0;
    drive_req(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1);
    step();
    drive_req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1);
    #1;
    chk("t4_a_reserve", 64'(reserve_o), 64'(32'h1 << 8));
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("t4_hold_valid", 64'(op_valid_o), 64'd1);
      chk("t4_hold_a", 64'(op_a_o), 64'h02);
      chk("t4_hold_b", 64'(op_b_o), 64'h66);
      chk("t4_full_ready", 64'(req_ready_o), 64'd0);
      chk("t4_no_reserve", 64'(reserve_o), 64'd0);
      step();
    end
    op_ready_i = 1'b1;
    #1;
    chk("t4_b_reserve", 64'(reserve_o), 64'(32'h1 << 9));
    chk("t4_b_ready", 64'(req_ready_o), 64'd1);
    step();
    chk("t4_b_op_a", 64'(op_a_o), 64'h11);
    chk("t4_b_op_b", 64'(op_b_o), 64'h22);
    chk("t4_b_op_rd", 64'(op_rd_o), 64'd9);
    chk("t4_stall_unchanged", 64'(stall_cnt_o), 64'd4);

    // Unused rs2 that is reserved (r8) must not stall
    drive_req(1'b1, 5'd3, 1'b1, 5'd8, 1'b0, 5'd10, 1'b0);
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    #1;
    chk("t5_no_reserve", 64'(reserve_o), 64'd0);
    chk("t5_fire_ready", 64'(req_ready_o), 64'd1);
    step();
    chk("t5_op_valid", 64'(op_valid_o), 64'd1);
    chk("t5_op_a", 64'(op_a_o), 64'h11);
    chk("t5_op_b_zero", 64'(op_b_o), 64'd0);
    chk("t5_op_rd_we", 64'(op_rd_we_o), 64'd0);
    chk("t5_stall_same", 64'(stall_cnt_o), 64'd4);

    // Mid-stream async reset: op held valid, request stalled on r9
    op_ready_i = 1'b0;
    drive_req(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    step();
    drive_req(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("t6_pre_valid", 64'(op_valid_o), 64'd1);
    chk("t6_pre_stall", 64'(stall_cnt_o), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(op_valid_o), 64'd0);
    chk("t6_rst_reserve", 64'(reserve_o), 64'd0);
    chk("t6_rst_stall", 64'(stall_cnt_o), 64'd0);
    chk("t6_rst_ready", 64'(req_ready_o), 64'd1);
    chk("t6_rst_op_a", 64'(op_a_o), 64'd0);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
